mode1_cbrt: RTL and testbench



---
 rtl/mode1_cbrt_if.sv | 24 ++
 rtl/mode1_cbrt.sv | 121 ++++++++++++
 tb/tb_mode1_cbrt.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/mode1_cbrt_if.sv
// Start/done handshake bundle for the bit-serial cube-root decoder.
// Latency: none (wiring only).
// Backpressure: none; the master watches busy and re-asserts start once idle.
// Ports: start/cube_in go from master to slave; busy, done, root_out,
//        rem_out and exact go from slave back to master.
interface mode1_cbrt_if;
  logic        start;
  logic [11:0] cube_in;
  logic        busy;
  logic        done;
  logic [3:0]  root_out;
  logic [11:0] rem_out;
  logic        exact;

  modport master (
    output start, cube_in,
    input  busy, done, root_out, rem_out, exact
  );

  modport slave (
    input  start, cube_in,
    output busy, done, root_out, rem_out, exact
  );
endinterface

// File: rtl/mode1_cbrt.sv
// Bit-serial integer cube root of a 12-bit value: floor root, remainder, exact flag.
// Latency: start accepted at edge N, done pulses for the cycle after edge N+5.
// Backpressure: start is ignored while busy; one result per 6 cycles at best.
// Ports: clk, rst (sync, active-high); bus (slave modport) carries
//        start/cube_in in and busy/done/root_out/rem_out/exact out.
module mode1_cbrt (
  input  logic         clk,
  input  logic         rst,
  mode1_cbrt_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [11:0] val_q, val_d;
  logic [3:0]  root_q, root_d;
  logic [1:0]  idx_q, idx_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [3:0]  root_out_q, root_out_d;
  logic [11:0] rem_out_q, rem_out_d;
  logic        exact_q, exact_d;

  logic [3:0]  trial;
  logic [11:0] trial_cube;
  logic [11:0] root_cube;
  logic [11:0] rem;

  // 15^3 = 3375 fits in 12 bits, so truncating the product loses nothing.
  function automatic logic [11:0] cube12(input logic [3:0] x);
    logic [11:0] w;
    w = {8'd0, x};
    return w * w * w;
  endfunction

  // Candidate root with the bit under test set; kept only if its cube still fits.
  assign trial      = root_q | (4'd1 << idx_q);
  assign trial_cube = cube12(trial);
  assign root_cube  = cube12(root_q);
  // val >= root^3 always holds once the search finishes, so no borrow.
  assign rem        = val_q - root_cube;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      val_q      <= 12'd0;
      root_q     <= 4'd0;
      idx_q      <= 2'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      root_out_q <= 4'd0;
      rem_out_q  <= 12'd0;
      exact_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      val_q      <= val_d;
      root_q     <= root_d;
      idx_q      <= idx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      root_out_q <= root_out_d;
      rem_out_q  <= rem_out_d;
      exact_q    <= exact_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    val_d      = val_q;
    root_d     = root_q;
    idx_d      = idx_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    root_out_d = root_out_q;
    rem_out_d  = rem_out_q;
    exact_d    = exact_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          val_d   = bus.cube_in;
          root_d  = 4'd0;
          idx_d   = 2'd3;
          busy_d  = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        if (trial_cube <= val_q) begin
          root_d = trial;
        end
        idx_d = idx_q - 2'd1;
        if (idx_q == 2'd0) begin
          state_d = DONE;
        end
      end
      DONE: begin
        root_out_d = root_q;
        rem_out_d  = rem;
        exact_d    = (rem == 12'd0);
        done_d     = 1'b1;
        busy_d     = 1'b0;
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.root_out = root_out_q;
  assign bus.rem_out  = rem_out_q;
  assign bus.exact    = exact_q;

endmodule

// File: tb/tb_mode1_cbrt.sv
// Self-checking bench for mode1_cbrt: cycle model plus directed literal checks.
`timescale 1ns/1ps
module tb_mode1_cbrt;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mode1_cbrt_if bus();

  mode1_cbrt dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Floor cube root by search over all 4-bit candidates.
  function automatic int ref_root(input int v);
    int r;
    r = 0;
    for (int c = 0; c < 16; c++) begin
      if (c * c * c <= v) r = c;
    end
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Behavioural model: an accepted request produces its result 5 edges later.
  int   m_val, m_cnt, m_root, m_rem;
  logic m_busy, m_done, m_exact;
  bit   m_valid = 1'b0;

  always @(posedge clk) begin
    m_valid <= 1'b1;
    if (rst) begin
      m_busy  <= 1'b0;
      m_done  <= 1'b0;
      m_root  <= 0;
      m_rem   <= 0;
      m_exact <= 1'b0;
      m_cnt   <= 0;
      m_val   <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_busy) begin
        if (m_cnt == 1) begin
          m_busy  <= 1'b0;
          m_done  <= 1'b1;
          m_root  <= ref_root(m_val);
          m_rem   <= m_val - ref_root(m_val) ** 3;
          m_exact <= (m_val == ref_root(m_val) ** 3);
        end
        m_cnt <= m_cnt - 1;
      end else if (bus.start) begin
        m_busy <= 1'b1;
        m_val  <= int'(bus.cube_in);
        m_cnt  <= 5;
      end
    end
  end

  // Every cycle: all DUT outputs against the model.
  always @(negedge clk) begin : cmp
    logic [18:0] act_v;
    logic [18:0] exp_v;
    if (m_valid) begin
      act_v = {bus.busy, bus.done, bus.root_out, bus.rem_out, bus.exact};
      exp_v = {m_busy, m_done, m_root[3:0], m_rem[11:0], m_exact};
      n_checks++;
      if (act_v == exp_v) n_pass++;
      else $display("FAIL model_cmp @%0t: got %h expected %h", $time, act_v, exp_v);
    end
  end

  // Issue one request and wait (bounded) for done; lit adds literal checks.
  task automatic run_op(input string name, input int v, input int er,
                        input int erem, input int eex, input bit lit);
    int lat, busy_cnt;
    @(negedge clk);
    bus.start   = 1'b1;
    bus.cube_in = v[11:0];
    @(negedge clk);
    bus.start   = 1'b0;
    bus.cube_in = 12'($urandom_range(0, 4095));
    lat = 1;
    busy_cnt = 0;
    while (!bus.done && lat < 20) begin
      if (bus.busy) busy_cnt++;
      @(negedge clk);
      lat++;
    end
    chk({name, "_done"}, int'(bus.done), 1);
    if (lit) begin
      chk({name, "_lat"},   lat, 6);
      chk({name, "_busy"},  busy_cnt, 5);
      chk({name, "_root"},  int'(bus.root_out), er);
      chk({name, "_rem"},   int'(bus.rem_out), erem);
      chk({name, "_exact"}, int'(bus.exact), eex);
    end
  endtask

  initial begin
    int lat, ndone;
    longint t_first;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.cube_in = 12'd0;
    repeat (2) @(negedge clk);
    chk("rst_busy",  int'(bus.busy), 0);
    chk("rst_done",  int'(bus.done), 0);
    chk("rst_root",  int'(bus.root_out), 0);
    chk("rst_rem",   int'(bus.rem_out), 0);
    chk("rst_exact", int'(bus.exact), 0);
    rst = 1'b0;

    chk("model_0",    ref_root(0), 0);
    chk("model_3374", ref_root(3374), 14);
    chk("model_3375", ref_root(3375), 15);
    chk("model_4095", ref_root(4095), 15);

    run_op("zero", 0,    0, 0,   1, 1'b1);
    run_op("max",  4095, 15, 720, 0, 1'b1);
    run_op("c15",  3375, 15, 0,   1, 1'b1);
    run_op("m216", 216,  6,  0,   1, 1'b1);
    run_op("s7",   7,    1,  6,   0, 1'b1);

    // start pulsed mid-operation must be dropped.
    @(negedge clk); bus.start = 1'b1; bus.cube_in = 12'd1000;
    @(negedge clk); bus.start = 1'b0; lat = 1;
    @(negedge clk); bus.start = 1'b1; bus.cube_in = 12'd27; lat = 2;
    @(negedge clk); bus.start = 1'b0; lat = 3;
    while (!bus.done && lat < 20) begin @(negedge clk); lat++; end
    chk("busy_start_lat",   lat, 6);
    chk("busy_start_root",  int'(bus.root_out), 10);
    chk("busy_start_rem",   int'(bus.rem_out), 0);
    chk("busy_start_exact", int'(bus.exact), 1);
    ndone = 0;
    repeat (12) begin @(negedge clk); if (bus.done) ndone++; end
    chk("busy_start_no_2nd_done", ndone, 0);

    // Back-to-back with start held high.
    @(negedge clk); bus.start = 1'b1; bus.cube_in = 12'd64;
    @(negedge clk); bus.cube_in = 12'd125; lat = 1;
    while (!bus.done && lat < 20) begin @(negedge clk); lat++; end
    t_first = $time;
    chk("b2b_lat1",  lat, 6);
    chk("b2b_root1", int'(bus.root_out), 4);
    chk("b2b_ex1",   int'(bus.exact), 1);
    @(negedge clk); bus.start = 1'b0; lat = 0;
    while (!bus.done && lat < 20) begin @(negedge clk); lat++; end
    chk("b2b_gap",   int'(($time - t_first) / 10), 6);
    chk("b2b_root2", int'(bus.root_out), 5);
    chk("b2b_ex2",   int'(bus.exact), 1);

    // Reset in the middle of an operation.
    @(negedge clk); bus.start = 1'b1; bus.cube_in = 12'd3000;
    @(negedge clk); bus.start = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("midrst_busy",  int'(bus.busy), 0);
    chk("midrst_done",  int'(bus.done), 0);
    chk("midrst_root",  int'(bus.root_out), 0);
    chk("midrst_rem",   int'(bus.rem_out), 0);
    chk("midrst_exact", int'(bus.exact), 0);
    ndone = 0;
    repeat (12) begin @(negedge clk); if (bus.done) ndone++; end
    chk("midrst_no_done", ndone, 0);
    run_op("after_rst", 512, 8, 0, 1, 1'b1);

    // mode1 round trip: (a+b)^3 for all 3-bit a, b.
    for (int a = 0; a < 8; a++) begin
      for (int b = 0; b < 8; b++) begin
        run_op($sformatf("rt_%0d_%0d", a, b), (a + b) ** 3, a + b, 0, 1, 1'b1);
      end
    end

    // Full input sweep; the compare process checks each result.
    for (int v = 0; v < 4096; v++) begin
      run_op($sformatf("sweep_%0d", v), v, 0, 0, 0, 1'b0);
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
